// File: rtl/bs_fetch_ctrl_pkg.sv
// Shared types and constants for the bitstream fetch controller.
// Holds the state encoding, the burst-length width and the FIFO capacity helpers.
package bs_fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        REQ,
        DATA,
        DRAIN,
        FINISH
    } fetch_state_t;

    // A burst length must be able to encode BURST_LEN itself, hence the +1.
    function automatic int burst_w(input int burst_len);
        return $clog2(burst_len) + 1;
    endfunction

    function automatic int fifo_cap(input int addr_bits);
        return (1 << addr_bits) - 1;
    endfunction

    localparam int BURST_W  = burst_w(16);
    localparam int FIFO_CAP = fifo_cap(7);

endpackage

// File: rtl/bs_fetch_ctrl_if.sv
// DDR read-port and FIFO write-port bundle used by the fetch controller.
// The master modport is the controller side.
interface bs_fetch_ctrl_if
    import bs_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_BITS     = 7,
    parameter int DATA_BITS     = 16,
    parameter int DDR_ADDR_BITS = 25,
    parameter int LEN_W         = BURST_W
);

    logic [ADDR_BITS:0]     fifo_nword;
    logic                   fifo_wr;
    logic [DATA_BITS-1:0]   fifo_data;

    logic                   ddr_rd_req;
    logic [DDR_ADDR_BITS-1:0] ddr_rd_addr;
    logic [LEN_W-1:0]       ddr_rd_len;
    logic                   ddr_rd_ack;
    logic [DATA_BITS-1:0]   ddr_rdata;
    logic                   ddr_rdata_valid;

    modport master (
        input  fifo_nword,
        output fifo_wr,
        output fifo_data,
        output ddr_rd_req,
        output ddr_rd_addr,
        output ddr_rd_len,
        input  ddr_rd_ack,
        input  ddr_rdata,
        input  ddr_rdata_valid
    );

    modport slave (
        output fifo_nword,
        input  fifo_wr,
        input  fifo_data,
        input  ddr_rd_req,
        input  ddr_rd_addr,
        input  ddr_rd_len,
        output ddr_rd_ack,
        output ddr_rdata,
        output ddr_rdata_valid
    );

endinterface

// File: rtl/bs_fetch_ctrl_admit.sv
// Burst admission: picks the next burst length and checks that the FIFO
// can absorb the whole burst.
module bs_fetch_admit
    import bs_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_BITS = 7,
    parameter int BURST_LEN = 16,
    parameter int LEN_BITS  = 24,
    localparam int LEN_W    = burst_w(BURST_LEN)
) (
    input  logic [LEN_BITS-1:0]  remaining,
    input  logic [ADDR_BITS:0]   fifo_nword,
    output logic [LEN_W-1:0]     len,
    output logic                 fits
);

    localparam int SUM_W = ADDR_BITS + 2;
    localparam logic [SUM_W-1:0]    CAP       = SUM_W'(fifo_cap(ADDR_BITS));
    localparam logic [LEN_BITS-1:0] BURST_MAX = LEN_BITS'(BURST_LEN);

    // One extra bit on the sum so a nearly full FIFO plus a full burst cannot wrap.
    always_comb begin
        len = LEN_W'(BURST_LEN);
        if (remaining < BURST_MAX) begin
            len = remaining[LEN_W-1:0];
        end
        fits = ({1'b0, fifo_nword} + SUM_W'(len)) <= CAP;
    end

endmodule

// File: rtl/bs_fetch_ctrl.sv
// Sequences DDR burst reads into the bitstream FIFO write port, one burst
// outstanding at a time, with abort and completion reporting.
module bs_fetch_ctrl
    import bs_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_BITS     = 7,
    parameter int DATA_BITS     = 16,
    parameter int BURST_LEN     = 16,
    parameter int DDR_ADDR_BITS = 25,
    parameter int LEN_BITS      = 24
) (
    input  logic                     clk,
    input  logic                     aclr,
    input  logic                     start,
    input  logic [DDR_ADDR_BITS-1:0] base_addr,
    input  logic [LEN_BITS-1:0]      total_words,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic [LEN_BITS-1:0]      words_fetched,
    bs_fetch_ctrl_if.master          bus
);

    localparam int LEN_W = burst_w(BURST_LEN);
    localparam logic [LEN_W-1:0]    ONE_BEAT = LEN_W'(1);
    localparam logic [LEN_BITS-1:0] ONE_WORD = LEN_BITS'(1);

    fetch_state_t             state;
    logic [DDR_ADDR_BITS-1:0] cur_addr;
    logic [LEN_BITS-1:0]      remaining;
    logic [LEN_W-1:0]         beat_cnt;
    logic                     abort_seen;
    logic [LEN_W-1:0]         adm_len;
    logic                     adm_fits;

    bs_fetch_admit #(
        .ADDR_BITS (ADDR_BITS),
        .BURST_LEN (BURST_LEN),
        .LEN_BITS  (LEN_BITS)
    ) u_admit (
        .remaining  (remaining),
        .fifo_nword (bus.fifo_nword),
        .len        (adm_len),
        .fits       (adm_fits)
    );

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state           <= IDLE;
            cur_addr        <= '0;
            remaining       <= '0;
            beat_cnt        <= '0;
            abort_seen      <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            words_fetched   <= '0;
            bus.fifo_wr     <= 1'b0;
            bus.fifo_data   <= '0;
            bus.ddr_rd_req  <= 1'b0;
            bus.ddr_rd_addr <= '0;
            bus.ddr_rd_len  <= '0;
        end else begin
            done        <= 1'b0;
            bus.fifo_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (total_words == '0) begin
                            state <= FINISH;
                        end else begin
                            cur_addr      <= base_addr;
                            remaining     <= total_words;
                            words_fetched <= '0;
                            state         <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (abort) begin
                        state <= FINISH;
                    end else if (adm_fits) begin
                        bus.ddr_rd_addr <= cur_addr;
                        bus.ddr_rd_len  <= adm_len;
                        bus.ddr_rd_req  <= 1'b1;
                        state           <= REQ;
                    end
                end
                // A request cannot be withdrawn, so an abort here is remembered until ack.
                REQ: begin
                    if (bus.ddr_rd_ack) begin
                        bus.ddr_rd_req <= 1'b0;
                        beat_cnt       <= bus.ddr_rd_len;
                        cur_addr       <= cur_addr + DDR_ADDR_BITS'(bus.ddr_rd_len);
                        abort_seen     <= 1'b0;
                        state          <= (abort || abort_seen) ? DRAIN : DATA;
                    end else if (abort) begin
                        abort_seen <= 1'b1;
                    end
                end
                // A beat arriving together with abort is consumed but not written.
                DATA: begin
                    if (bus.ddr_rdata_valid) begin
                        beat_cnt <= beat_cnt - ONE_BEAT;
                        if (!abort) begin
                            bus.fifo_wr   <= 1'b1;
                            bus.fifo_data <= DATA_BITS'(bus.ddr_rdata);
                            words_fetched <= words_fetched + ONE_WORD;
                            remaining     <= remaining - ONE_WORD;
                        end
                        if (beat_cnt == ONE_BEAT) begin
                            state <= (abort || remaining == ONE_WORD) ? FINISH : CHECK;
                        end else if (abort) begin
                            state <= DRAIN;
                        end
                    end else if (abort) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.ddr_rdata_valid) begin
                        beat_cnt <= beat_cnt - ONE_BEAT;
                        if (beat_cnt == ONE_BEAT) begin
                            state <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bs_fetch_ctrl.sv
// Directed self-checking bench for bs_fetch_ctrl with a simple DDR responder
// that returns the low bits of each word address as its data.
module tb_bs_fetch_ctrl;
    import bs_fetch_ctrl_pkg::*;

    localparam int AB  = 7;
    localparam int DB  = 16;
    localparam int BL  = 16;
    localparam int DAB = 25;
    localparam int LB  = 24;
    localparam int LW  = burst_w(BL);

    logic           clk = 1'b0;
    logic           aclr;
    logic           start;
    logic           abort;
    logic [DAB-1:0] base_addr;
    logic [LB-1:0]  total_words;
    logic           busy;
    logic           done;
    logic [LB-1:0]  words_fetched;

    logic [AB:0]    nword;
    logic           rsp_ack;
    logic           rsp_valid;
    logic [DB-1:0]  rsp_data;
    logic           stray_valid;
    logic [DB-1:0]  stray_data;
    bit             rsp_busy;

    int checks = 0;
    int failures = 0;
    int beats_sent = 0;
    int done_cnt = 0;

    logic [DB-1:0]  wr_q[$];
    logic [DAB-1:0] req_addr_q[$];
    logic [LW-1:0]  req_len_q[$];
    logic           prev_req = 1'b0;

    bs_fetch_ctrl_if #(
        .ADDR_BITS     (AB),
        .DATA_BITS     (DB),
        .DDR_ADDR_BITS (DAB),
        .LEN_W         (LW)
    ) bus ();

    bs_fetch_ctrl #(
        .ADDR_BITS     (AB),
        .DATA_BITS     (DB),
        .BURST_LEN     (BL),
        .DDR_ADDR_BITS (DAB),
        .LEN_BITS      (LB)
    ) dut (
        .clk           (clk),
        .aclr          (aclr),
        .start         (start),
        .base_addr     (base_addr),
        .total_words   (total_words),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .words_fetched (words_fetched),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    assign bus.fifo_nword      = nword;
    assign bus.ddr_rd_ack      = rsp_ack;
    assign bus.ddr_rdata       = stray_valid ? stray_data : rsp_data;
    assign bus.ddr_rdata_valid = rsp_valid | stray_valid;

    // Records FIFO writes, new burst requests and done pulses.
    always @(negedge clk) begin
        if (bus.fifo_wr) wr_q.push_back(bus.fifo_data);
        if (bus.ddr_rd_req && !prev_req) begin
            req_addr_q.push_back(bus.ddr_rd_addr);
            req_len_q.push_back(bus.ddr_rd_len);
        end
        prev_req <= bus.ddr_rd_req;
        if (done) done_cnt <= done_cnt + 1;
    end

    // DDR model: ack two cycles after seeing a request, then beats back-to-back.
    initial begin : ddr_model
        logic [DAB-1:0] a;
        int l;
        rsp_ack = 1'b0;
        rsp_valid = 1'b0;
        rsp_data = '0;
        rsp_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.ddr_rd_req && !aclr) begin
                rsp_busy = 1'b1;
                a = bus.ddr_rd_addr;
                l = int'(bus.ddr_rd_len);
                repeat (2) @(negedge clk);
                rsp_ack = 1'b1;
                @(negedge clk);
                rsp_ack = 1'b0;
                for (int i = 0; i < l; i++) begin
                    rsp_data = DB'(a + DAB'(i));
                    rsp_valid = 1'b1;
                    beats_sent++;
                    @(negedge clk);
                end
                rsp_valid = 1'b0;
                rsp_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [DAB-1:0] base, input logic [LB-1:0] total);
        @(negedge clk);
        base_addr = base;
        total_words = total;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int limit, input string tag);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == d0) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin : main
        int w0;
        int r0;
        int d0;
        int w1;
        int bs0;
        int n;

        aclr = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        base_addr = '0;
        total_words = '0;
        nword = '0;
        stray_valid = 1'b0;
        stray_data = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_words", 32'(words_fetched), 32'd0);
        checkOutput("rst_fifo_wr", 32'(bus.fifo_wr), 32'd0);
        checkOutput("rst_req", 32'(bus.ddr_rd_req), 32'd0);
        checkOutput("rst_len", 32'(bus.ddr_rd_len), 32'd0);
        aclr = 1'b0;

        $display("[TB] multi-burst fetch of 40 words");
        w0 = wr_q.size(); r0 = req_addr_q.size(); d0 = done_cnt;
        applyStimulus(25'h100, 24'd40);
        waitDone(2000, "t1_done");
        repeat (3) @(negedge clk);
        checkOutput("t1_req_count", 32'(req_addr_q.size() - r0), 32'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("t1_req%0d_addr", i), 32'(req_addr_q[r0+i]), 32'h100 + 32'(16 * i));
            checkOutput($sformatf("t1_req%0d_len", i), 32'(req_len_q[r0+i]), (i == 2) ? 32'd8 : 32'd16);
        end
        checkOutput("t1_wr_count", 32'(wr_q.size() - w0), 32'd40);
        for (int k = 0; k < 40; k++) begin
            checkOutput($sformatf("t1_wr%0d", k), 32'(wr_q[w0+k]), 32'h100 + 32'(k));
        end
        checkOutput("t1_done_count", 32'(done_cnt - d0), 32'd1);
        checkOutput("t1_words", 32'(words_fetched), 32'd40);
        checkOutput("t1_busy_end", 32'(busy), 32'd0);

        $display("[TB] zero-length fetch");
        w0 = wr_q.size(); r0 = req_addr_q.size(); d0 = done_cnt;
        @(negedge clk);
        base_addr = 25'h777;
        total_words = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("t2_done_early", 32'(done), 32'd0);
        checkOutput("t2_busy", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("t2_done", 32'(done), 32'd1);
        checkOutput("t2_busy_end", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("t2_req_count", 32'(req_addr_q.size() - r0), 32'd0);
        checkOutput("t2_wr_count", 32'(wr_q.size() - w0), 32'd0);
        checkOutput("t2_done_count", 32'(done_cnt - d0), 32'd1);

        $display("[TB] admission held off by a nearly full FIFO");
        w0 = wr_q.size(); r0 = req_addr_q.size(); d0 = done_cnt;
        nword = 8'd115;
        applyStimulus(25'h400, 24'd16);
        repeat (10) @(negedge clk);
        checkOutput("t3_no_req_115", 32'(req_addr_q.size() - r0), 32'd0);
        checkOutput("t3_busy", 32'(busy), 32'd1);
        applyStimulus(25'h5000, 24'd7);
        @(negedge clk);
        stray_data = 16'hdead;
        stray_valid = 1'b1;
        @(negedge clk);
        stray_valid = 1'b0;
        nword = 8'd112;
        repeat (5) @(negedge clk);
        checkOutput("t3_no_req_112", 32'(req_addr_q.size() - r0), 32'd0);
        checkOutput("t3_no_stray_wr", 32'(wr_q.size() - w0), 32'd0);
        checkOutput("t3_words_held", 32'(words_fetched), 32'd0);
        nword = 8'd111;
        waitDone(500, "t3_done");
        repeat (3) @(negedge clk);
        checkOutput("t3_req_count", 32'(req_addr_q.size() - r0), 32'd1);
        checkOutput("t3_req_addr", 32'(req_addr_q[r0]), 32'h400);
        checkOutput("t3_req_len", 32'(req_len_q[r0]), 32'd16);
        checkOutput("t3_wr_count", 32'(wr_q.size() - w0), 32'd16);
        checkOutput("t3_wr_first", 32'(wr_q[w0]), 32'h400);
        checkOutput("t3_wr_last", 32'(wr_q[w0+15]), 32'h40f);
        checkOutput("t3_words", 32'(words_fetched), 32'd16);
        checkOutput("t3_done_count", 32'(done_cnt - d0), 32'd1);
        nword = '0;

        $display("[TB] abort after five beats");
        w0 = wr_q.size(); r0 = req_addr_q.size(); d0 = done_cnt; bs0 = beats_sent;
        applyStimulus(25'h800, 24'd32);
        n = 0;
        while (beats_sent - bs0 < 5 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (beats_sent - bs0 < 5) checkOutput("t4_beats_timeout", 32'(beats_sent - bs0), 32'd5);
        #1 abort = 1'b1;
        waitDone(500, "t4_done");
        checkOutput("t4_beats_at_done", 32'(beats_sent - bs0), 32'd16);
        @(negedge clk);
        abort = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("t4_req_count", 32'(req_addr_q.size() - r0), 32'd1);
        checkOutput("t4_wr_count", 32'(wr_q.size() - w0), 32'd5);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("t4_wr%0d", k), 32'(wr_q[w0+k]), 32'h800 + 32'(k));
        end
        checkOutput("t4_words", 32'(words_fetched), 32'd5);
        checkOutput("t4_done_count", 32'(done_cnt - d0), 32'd1);

        $display("[TB] reset during data phase then restart");
        w0 = wr_q.size(); d0 = done_cnt;
        applyStimulus(25'h2000, 24'd32);
        n = 0;
        while (wr_q.size() - w0 < 4 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (wr_q.size() - w0 < 4) checkOutput("t5_wr_timeout", 32'(wr_q.size() - w0), 32'd4);
        #1 aclr = 1'b1;
        @(negedge clk);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_fifo_wr", 32'(bus.fifo_wr), 32'd0);
        checkOutput("t5_req", 32'(bus.ddr_rd_req), 32'd0);
        checkOutput("t5_words", 32'(words_fetched), 32'd0);
        checkOutput("t5_addr", 32'(bus.ddr_rd_addr), 32'd0);
        aclr = 1'b0;
        w1 = wr_q.size();
        n = 0;
        while (rsp_busy && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checkOutput("t5_no_wr_after_aclr", 32'(wr_q.size() - w1), 32'd0);
        checkOutput("t5_no_done", 32'(done_cnt - d0), 32'd0);

        w0 = wr_q.size(); r0 = req_addr_q.size(); d0 = done_cnt;
        applyStimulus(25'h3000, 24'd3);
        waitDone(500, "t5_done");
        repeat (3) @(negedge clk);
        checkOutput("t5_req_count", 32'(req_addr_q.size() - r0), 32'd1);
        checkOutput("t5_req_addr", 32'(req_addr_q[r0]), 32'h3000);
        checkOutput("t5_req_len", 32'(req_len_q[r0]), 32'd3);
        checkOutput("t5_wr_count", 32'(wr_q.size() - w0), 32'd3);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("t5_wr%0d", k), 32'(wr_q[w0+k]), 32'h3000 + 32'(k));
        end
        checkOutput("t5_words_new", 32'(words_fetched), 32'd3);
        checkOutput("t5_done_count", 32'(done_cnt - d0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
